// File: rtl/cordic_iterative_engine_if.sv
// Operand/result handshake bundle for the iterative CORDIC engine.
// master = operand producer / result consumer, slave = engine.
interface cordic_iterative_engine_if #(
  parameter int WIDTH = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_mode;
  logic signed [WIDTH-1:0] in_x;
  logic signed [WIDTH-1:0] in_y;
  logic signed [WIDTH-1:0] in_z;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_x;
  logic signed [WIDTH-1:0] out_y;
  logic signed [WIDTH-1:0] out_z;
  logic                    out_sat;

  modport master (
    output in_valid, in_mode, in_x, in_y, in_z, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_z, out_sat
  );

  modport slave (
    input  in_valid, in_mode, in_x, in_y, in_z, out_ready,
    output in_ready, out_valid, out_x, out_y, out_z, out_sat
  );
endinterface

// File: rtl/cordic_iterative_engine.sv
// Iterative CORDIC core: one micro-rotation per clock, rotation/vectoring
// selected per operand, quadrant pre-rotation at load, saturating x/y outputs.
module cordic_iterative_engine #(
  parameter int WIDTH      = 32,
  parameter int FRAC       = 16,
  parameter int ITERATIONS = 16
) (
  input  logic                        clock,
  input  logic                        reset_n,
  cordic_iterative_engine_if.slave    bus
);

  localparam int XW = WIDTH + 2;
  localparam int SH = 30 - FRAC;
  localparam logic [32:0] HALF_PI_Q30 = 33'd1686629713;
  localparam logic [32:0] RND         = 33'd1 << (SH - 1);
  localparam logic signed [WIDTH-1:0] P = WIDTH'((HALF_PI_Q30 + RND) >> SH);
  localparam logic signed [XW-1:0] MAXV = {3'b000, {(WIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] MINV = {3'b111, {(WIDTH-1){1'b0}}};
  localparam logic [4:0] LAST = 5'(ITERATIONS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [4:0]              iter_q, iter_d;
  logic                    mode_q, mode_d;
  logic signed [XW-1:0]    x_q, x_d, y_q, y_d;
  logic signed [WIDTH-1:0] z_q, z_d;
  logic signed [WIDTH-1:0] ox_q, ox_d, oy_q, oy_d, oz_q, oz_d;
  logic                    sat_q, sat_d;

  logic signed [XW-1:0]    xin, yin, lx, ly, xs, ys, x_n, y_n;
  logic signed [WIDTH-1:0] zin, lz, z_n, a_i, cx, cy;
  logic                    sx, sy, d_pos, load, in_rdy;

  function automatic logic [32:0] atan_q30(input logic [4:0] idx);
    case (idx)
      5'd0:  atan_q30 = 33'd843314857;
      5'd1:  atan_q30 = 33'd497837829;
      5'd2:  atan_q30 = 33'd263043837;
      5'd3:  atan_q30 = 33'd133525159;
      5'd4:  atan_q30 = 33'd67021687;
      5'd5:  atan_q30 = 33'd33543516;
      5'd6:  atan_q30 = 33'd16775851;
      5'd7:  atan_q30 = 33'd8388437;
      5'd8:  atan_q30 = 33'd4194283;
      5'd9:  atan_q30 = 33'd2097149;
      5'd10: atan_q30 = 33'd1048576;
      5'd11: atan_q30 = 33'd524288;
      5'd12: atan_q30 = 33'd262144;
      5'd13: atan_q30 = 33'd131072;
      5'd14: atan_q30 = 33'd65536;
      5'd15: atan_q30 = 33'd32768;
      5'd16: atan_q30 = 33'd16384;
      5'd17: atan_q30 = 33'd8192;
      5'd18: atan_q30 = 33'd4096;
      5'd19: atan_q30 = 33'd2048;
      5'd20: atan_q30 = 33'd1024;
      5'd21: atan_q30 = 33'd512;
      5'd22: atan_q30 = 33'd256;
      5'd23: atan_q30 = 33'd128;
      5'd24: atan_q30 = 33'd64;
      5'd25: atan_q30 = 33'd32;
      5'd26: atan_q30 = 33'd16;
      5'd27: atan_q30 = 33'd8;
      5'd28: atan_q30 = 33'd4;
      5'd29: atan_q30 = 33'd2;
      5'd30: atan_q30 = 33'd1;
      default: atan_q30 = 33'd0;
    endcase
  endfunction

  assign xin = {{2{bus.in_x[WIDTH-1]}}, bus.in_x};
  assign yin = {{2{bus.in_y[WIDTH-1]}}, bus.in_y};
  assign zin = bus.in_z;
  assign a_i = WIDTH'((atan_q30(iter_q) + RND) >> SH);

  // Quadrant fold so the micro-rotations only ever cover +/- pi/2.
  always_comb begin
    lx = xin;
    ly = yin;
    lz = zin;
    if (bus.in_mode) begin
      if (xin[XW-1]) begin
        if (!yin[XW-1]) begin
          lx = yin;  ly = -xin; lz = zin + P;
        end else begin
          lx = -yin; ly = xin;  lz = zin - P;
        end
      end
    end else if (zin > P) begin
      lx = -yin; ly = xin;  lz = zin - P;
    end else if (zin < -P) begin
      lx = yin;  ly = -xin; lz = zin + P;
    end
  end

  always_comb begin
    d_pos = mode_q ? y_q[XW-1] : ~z_q[WIDTH-1];
    xs    = x_q >>> iter_q;
    ys    = y_q >>> iter_q;
    if (d_pos) begin
      x_n = x_q - ys;
      y_n = y_q + xs;
      z_n = z_q - a_i;
    end else begin
      x_n = x_q + ys;
      y_n = y_q - xs;
      z_n = z_q + a_i;
    end
  end

  always_comb begin
    sx = 1'b0;
    sy = 1'b0;
    cx = x_n[WIDTH-1:0];
    cy = y_n[WIDTH-1:0];
    if (x_n > MAXV)      begin cx = MAXV[WIDTH-1:0]; sx = 1'b1; end
    else if (x_n < MINV) begin cx = MINV[WIDTH-1:0]; sx = 1'b1; end
    if (y_n > MAXV)      begin cy = MAXV[WIDTH-1:0]; sy = 1'b1; end
    else if (y_n < MINV) begin cy = MINV[WIDTH-1:0]; sy = 1'b1; end
  end

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    mode_d  = mode_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    oz_d    = oz_q;
    sat_d   = sat_q;
    in_rdy  = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        in_rdy = 1'b1;
        load   = bus.in_valid;
      end
      RUN: begin
        x_d    = x_n;
        y_d    = y_n;
        z_d    = z_n;
        iter_d = iter_q + 5'd1;
        if (iter_q == LAST) begin
          state_d = DONE;
          ox_d    = cx;
          oy_d    = cy;
          oz_d    = z_n;
          sat_d   = sx | sy;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          in_rdy = 1'b1;
          load   = bus.in_valid;
          if (!bus.in_valid) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = RUN;
      iter_d  = '0;
      mode_d  = bus.in_mode;
      x_d     = lx;
      y_d     = ly;
      z_d     = lz;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      iter_q  <= '0;
      mode_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      oz_q    <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      oz_q    <= oz_d;
      sat_q   <= sat_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_x     = ox_q;
  assign bus.out_y     = oy_q;
  assign bus.out_z     = oz_q;
  assign bus.out_sat   = sat_q;

endmodule

// File: doc/cordic_iterative_engine.md
# cordic_iterative_engine

Parametrised, iterative CORDIC engine for the VECTOR datapath. Supports rotation and vectoring modes at run time, with quadrant pre-rotation, valid/ready handshakes on both sides, and saturating outputs. One micro-rotation is performed per clock using a single shared x/y/z datapath and an internal arctangent ROM. It succeeds the fixed-width per-stage Z update as the reusable CORDIC core for magnitude/phase and sin/cos users.

## Interface
- WIDTH, 32: signed two's-complement width of x, y, z on all ports; 8..32.
- FRAC, 16: fractional bits of x, y, z (radians for z); FRAC ≤ WIDTH-3.
- ITERATIONS, 16: micro-rotations per operation; 1..min(WIDTH-1, 31).
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand present.
- in_ready  out  1  engine accepts operand this cycle.
- in_mode  in  1  0 = rotation (drive z to 0), 1 = vectoring (drive y to 0).
- in_x, in_y, in_z  in  WIDTH each  operands.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes result.
- out_x, out_y, out_z  out  WIDTH each  results (x, y include CORDIC gain K ≈ 1.64676; no compensation).
- out_sat  out  1  out_x or out_y saturated.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE: in_ready=1; in_valid → load, go to RUN, iteration counter i=0.
  - RUN: one iteration per cycle; after iteration ITERATIONS-1 go to DONE.
  - DONE: out_valid=1; results and out_sat held stable until out_ready.
- in_ready = (state==IDLE) | (state==DONE & out_ready). In DONE with out_ready & in_valid, the result is retired and the new operand is loaded on the same edge, going to RUN. With out_ready and no in_valid, go to IDLE.
- Internal x, y are WIDTH+2 bits (sign-extended at load); z is WIDTH bits with two's-complement wrap.
- Pre-rotation at load, with P = π/2 in the FRAC format:
  - Vectoring, x<0, y≥0: x'=y, y'=-x, z'=z+P.
  - Vectoring, x<0, y<0: x'=-y, y'=x, z'=z-P.
  - Rotation, z>P: x'=-y, y'=x, z'=z-P.
  - Rotation, z<-P: x'=y, y'=-x, z'=z+P.
  - Otherwise: load unchanged.
- Direction d: vectoring d = (y<0) ? +1 : -1; rotation d = (z≥0) ? +1 : -1.
- Iteration i, with shifts arithmetic on the pre-update values:
  - x ← x - d·(y>>>i)
  - y ← y + d·(x>>>i)
  - z ← z - d·A[i]
- ROM A[i] = round(atan(2^-i)·2^30) for i=0..31, right-shifted by (30-FRAC) with round-half-up. P = round(π/2·2^FRAC).
- Outputs: out_x, out_y are the internal x, y clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. out_sat=1 if either is clamped. out_z = z.

## Timing
- Reset (async assert, sync release): state=IDLE, i=0; in_ready=1 after release; out_valid=0, out_x=out_y=out_z=0, out_sat=0.
- Acceptance at edge N → out_valid rises after edge N+ITERATIONS.
- Sustained throughput with out_ready held 1: one result per ITERATIONS+1 cycles.
- Output registers change only at DONE entry; they are stable while out_valid=1 & out_ready=0.
- in_* is sampled only on an accepting edge; changes at other times are ignored.
- reset_n low mid-RUN or mid-DONE: the operation is discarded; no out_valid after release until a new acceptance.
- out_ready while not in DONE: ignored.

## Test plan
All cases use defaults (Q16.16, 16 iterations), tolerance ±8 LSB unless stated.
- Vectoring, x=65536, y=65536, z=0 → out_z≈51472 (π/4), out_x≈152623, |out_y|≤8, out_sat=0, out_valid exactly 16 cycles after accept.
- Rotation, x=39797 (1/K), y=0, z=34315 (π/6) → out_x≈56756, out_y≈32768, |out_z|≤8.
- Pre-rotation: vectoring x=-65536, y=0 → out_z≈±205887 (π, either sign), out_x≈107923. Rotation x=39797, y=0, z=-154415 (-3π/4) → out_x≈out_y≈-46341.
- Saturation: vectoring x=y=0x7FFFFFFF → out_x=0x7FFFFFFF, out_sat=1, out_z≈51472.
- Backpressure/back-to-back: hold out_ready=0 for 10 cycles in DONE → outputs stable, in_ready=0. Then raise out_ready together with in_valid → retire and accept on the same edge; next out_valid 16 cycles later.
- Reset: pull reset_n low at RUN i=7 → all outputs 0 immediately; after release in_ready=1, no spurious out_valid for 40 cycles.
